// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller sitting directly upstream of an
// external 8-bit combinational ALU. It accepts one command per handshake,
// reads operands from a small register file (or takes an immediate), drives
// the ALU, captures its result and flags, and writes them back. Multi-bit
// SHL/SHR commands are performed by feeding the ALU output back into operand
// A once per cycle, so the ALU itself only ever shifts by one bit.
module alu_exec_ctrl #(
  parameter int NREG = 4,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [1:0]    cmd_rd,
  input  logic [1:0]    cmd_rs,
  input  logic          cmd_use_imm,
  input  logic [DW-1:0] cmd_imm,
  input  logic [2:0]    cmd_cnt,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_v,
  output logic [3:0]    flags,
  output logic          done,
  output logic          err,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  // ALU_Sel encodings this controller has to treat specially.
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Register file, plus the command fields latched at accept time.
  logic [DW-1:0] reg_file [NREG];
  logic [3:0]    op_q;
  logic [1:0]    rd_q;
  logic [2:0]    iter_q;

  // Result and flags captured on the last EXEC cycle, committed in WB.
  logic [DW-1:0] res_hold;
  logic [3:0]    flag_hold;

  logic accept;
  logic iter_more;
  logic op_is_shift_q;
  logic op_writes_reg;
  logic op_writes_flags;
  logic op_undefined;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  assign accept          = cmd_valid && cmd_ready;
  assign op_is_shift_q   = is_shift(op_q);
  assign iter_more       = op_is_shift_q && (iter_q != 3'd0);
  assign op_writes_reg   = (op_q <= OP_INC);
  assign op_writes_flags = (op_q <= OP_CMP);
  assign op_undefined    = (op_q > OP_CMP);

  // Debug read port is a plain combinational read with no write bypass.
  assign dbg_data = reg_file[dbg_sel];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and handshake/completion outputs.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!iter_more) begin
          next_state = ST_WB;
        end
      end
      ST_WB: begin
        done       = 1'b1;
        err        = op_undefined;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Latch the command and drive the ALU inputs; these are only non-zero while in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      iter_q  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            rd_q    <= cmd_rd;
            iter_q  <= is_shift(cmd_op) ? cmd_cnt : 3'd0;
            alu_a   <= reg_file[cmd_rd];
            alu_b   <= cmd_use_imm ? cmd_imm : reg_file[cmd_rs];
            alu_sel <= cmd_op;
          end
        end
        ST_EXEC: begin
          if (iter_more) begin
            alu_a  <= alu_result;
            iter_q <= iter_q - 3'd1;
          end else begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
          end
        end
        default: begin
          alu_a   <= '0;
          alu_b   <= '0;
          alu_sel <= '0;
        end
      endcase
    end
  end

  // Capture the ALU output on the final EXEC cycle so flags reflect only the last shift step.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_hold  <= '0;
      flag_hold <= '0;
    end else if ((state == ST_EXEC) && !iter_more) begin
      res_hold  <= alu_result;
      flag_hold <= {alu_z, alu_n, alu_c, alu_v};
    end
  end

  // Commit in WB: ops 0-8 write the register and flags, CMP writes flags only, undefined ops write nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        reg_file[i] <= '0;
      end
      flags <= '0;
    end else if (state == ST_WB) begin
      if (op_writes_reg) begin
        reg_file[rd_q] <= res_hold;
      end
      if (op_writes_flags) begin
        flags <= flag_hold;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: drives alu_exec_ctrl with directed and random commands,
// emulates the external single-step ALU, and checks every completion against
// a reference model through a scoreboard queue consumed by a separate monitor.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_rs;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic [2:0] cmd_cnt;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_z;
  logic       alu_n;
  logic       alu_c;
  logic       alu_v;
  logic [3:0] flags;
  logic       done;
  logic       err;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd;
    logic       err;
    logic [3:0] flags;
    logic [7:0] value;
    int         acc_cyc;
    int         n_exec;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int done_seen = 0;

  // Reference architectural state.
  logic [7:0] ref_regs [4];
  logic [3:0] ref_flags;

  logic [8:0] alu_tmp;

  alu_exec_ctrl #(.NREG(4), .DW(8)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_rd(cmd_rd),
    .cmd_rs(cmd_rs),
    .cmd_use_imm(cmd_use_imm),
    .cmd_imm(cmd_imm),
    .cmd_cnt(cmd_cnt),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_sel(alu_sel),
    .alu_result(alu_result),
    .alu_z(alu_z),
    .alu_n(alu_n),
    .alu_c(alu_c),
    .alu_v(alu_v),
    .flags(flags),
    .done(done),
    .err(err),
    .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count rising edges so latency can be measured in cycles.
  always @(posedge clk) cycle <= cycle + 1;

  // External ALU emulation: one operation per cycle, SHL/SHR move by exactly one bit.
  always_comb begin
    alu_tmp    = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_sel)
      4'd0: begin
        alu_tmp    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_tmp[7:0];
        alu_c      = alu_tmp[8];
        alu_v      = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd1, 4'd9: begin
        alu_tmp    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_tmp[7:0];
        alu_c      = alu_tmp[8];
        alu_v      = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ~alu_a;
      4'd6: begin
        alu_result = {alu_a[6:0], 1'b0};
        alu_c      = alu_a[7];
      end
      4'd7: begin
        alu_result = {1'b0, alu_a[7:1]};
        alu_c      = alu_a[0];
      end
      4'd8: begin
        alu_tmp    = {1'b0, alu_a} + 9'd1;
        alu_result = alu_tmp[7:0];
        alu_c      = alu_tmp[8];
        alu_v      = (alu_a == 8'h7F);
      end
      default: alu_result = '0;
    endcase
    alu_z = (alu_result == 8'h00);
    alu_n = alu_result[7];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_flags = 4'h0;
  endtask

  // Whole-command reference: multi-bit shifts computed in one step, V from signed-integer range.
  task automatic model_exec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                            input logic use_imm, input logic [7:0] imm, input logic [2:0] cnt,
                            output exp_t e);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic [15:0] wide;
    logic        c;
    logic        v;
    int          sa;
    int          sb_i;
    int          s;
    int          sh;
    a   = ref_regs[rd];
    b   = use_imm ? imm : ref_regs[rs];
    res = 8'h00;
    c   = 1'b0;
    v   = 1'b0;
    sa  = $signed(a);
    sb_i = $signed(b);
    sh  = int'(cnt) + 1;
    e.op = op;
    e.rd = rd;
    e.n_exec = ((op == 4'd6) || (op == 4'd7)) ? sh : 1;
    case (op)
      4'd0: begin
        res = a + b;
        c   = (int'(a) + int'(b)) > 255;
        s   = sa + sb_i;
        v   = (s > 127) || (s < -128);
      end
      4'd1, 4'd9: begin
        res = a - b;
        c   = int'(a) < int'(b);
        s   = sa - sb_i;
        v   = (s > 127) || (s < -128);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: begin
        wide = 16'(a) << sh;
        res  = wide[7:0];
        c    = wide[8];
      end
      4'd7: begin
        res = a >> sh;
        c   = a[sh-1];
      end
      4'd8: begin
        res = a + 8'd1;
        c   = (a == 8'hFF);
        s   = sa + 1;
        v   = s > 127;
      end
      default: res = 8'h00;
    endcase
    if (op > 4'd9) begin
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      ref_flags = {(res == 8'h00), res[7], c, v};
      if (op != 4'd9) ref_regs[rd] = res;
    end
    e.flags = ref_flags;
    e.value = ref_regs[rd];
  endtask

  // Issue one command, wait (bounded) for acceptance, and push the expected completion.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                               input logic use_imm, input logic [7:0] imm, input logic [2:0] cnt,
                               input bit expect_done, input bit hold_valid);
    exp_t       e;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    int         waited;
    cmd_op      = op;
    cmd_rd      = rd;
    cmd_rs      = rs;
    cmd_use_imm = use_imm;
    cmd_imm     = imm;
    cmd_cnt     = cnt;
    cmd_valid   = 1'b1;
    waited      = 0;
    while (!cmd_ready && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("accept_timeout", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    exp_a = ref_regs[rd];
    exp_b = use_imm ? imm : ref_regs[rs];
    model_exec(op, rd, rs, use_imm, imm, cnt, e);
    e.acc_cyc = cycle;
    if (expect_done) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("exec_alu_sel", alu_sel, op);
    checkOutput("exec_alu_a", alu_a, exp_a);
    checkOutput("exec_alu_b", alu_b, exp_b);
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_idle_alu();
    checkOutput("idle_alu_a", alu_a, 8'h00);
    checkOutput("idle_alu_b", alu_b, 8'h00);
    checkOutput("idle_alu_sel", alu_sel, 4'h0);
  endtask

  // Monitor: sweeps the register file after every reset release and pops the scoreboard on each done.
  initial begin
    exp_t e;
    logic prev_rst;
    prev_rst = 1'b1;
    dbg_sel  = 2'd0;
    forever begin
      @(negedge clk);
      if (prev_rst && !rst) begin
        for (int i = 0; i < 4; i++) begin
          dbg_sel = 2'(i);
          #1;
          checkOutput("reset_reg", dbg_data, 8'h00);
        end
      end
      prev_rst = rst;
      if (!rst) begin
        if (err && !done) begin
          checks++;
          failures++;
          $display("[TB] FAIL err_without_done: err=1 done=0, expected err only with done (t=%0t)", $time);
        end
        if (done) begin
          done_seen++;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: done=1 with nothing outstanding, expected done=0 (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            checkOutput("done_latency", cycle - e.acc_cyc, 1 + e.n_exec);
            checkOutput("err_pulse", err, e.err);
            @(posedge clk);
            #1;
            checkOutput("flags_after_wb", flags, e.flags);
            dbg_sel = e.rd;
            #1;
            checkOutput("reg_after_wb", dbg_data, e.value);
          end
        end
      end
    end
  end

  // Hard stop in case something never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [3:0] r_op;
  logic [1:0] r_rd;
  logic [1:0] r_rs;
  logic       r_imm_sel;
  logic [7:0] r_imm;
  logic [2:0] r_cnt;
  int         d0;

  // Main stimulus sequence: directed scenarios then a randomized run.
  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_rd      = '0;
    cmd_rs      = '0;
    cmd_use_imm = 1'b0;
    cmd_imm     = '0;
    cmd_cnt     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_cmd_ready", cmd_ready, 1'b1);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_flags", flags, 4'h0);
    check_idle_alu();

    $display("[TB] ADD signed overflow");
    applyStimulus(4'd3, 2'd0, 2'd0, 1'b1, 8'h7F, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'd0, 2'd0, 2'd0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
    wait_drain();
    checkOutput("add_ovf_flags", flags, 4'b0101);

    $display("[TB] CMP equal");
    applyStimulus(4'd3, 2'd1, 2'd0, 1'b1, 8'h05, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'd9, 2'd1, 2'd0, 1'b1, 8'h05, 3'd0, 1'b1, 1'b0);
    wait_drain();
    checkOutput("cmp_eq_flags", flags, 4'b1000);

    $display("[TB] SHL by three");
    applyStimulus(4'd3, 2'd2, 2'd0, 1'b1, 8'h81, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'd6, 2'd2, 2'd0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0);
    wait_drain();
    checkOutput("shl3_flags", flags, 4'b0000);

    $display("[TB] undefined op");
    applyStimulus(4'b1100, 2'd2, 2'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    wait_drain();
    checkOutput("undef_flags_kept", flags, 4'b0000);
    check_idle_alu();

    $display("[TB] reset abort during shift");
    applyStimulus(4'd3, 2'd3, 2'd0, 1'b1, 8'hF0, 3'd0, 1'b1, 1'b0);
    wait_drain();
    d0 = done_seen;
    applyStimulus(4'd7, 2'd3, 2'd0, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    checkOutput("abort_cmd_ready", cmd_ready, 1'b1);
    checkOutput("abort_flags", flags, 4'h0);
    repeat (12) @(negedge clk);
    #1;
    checkOutput("abort_no_done", done_seen - d0, 0);
    applyStimulus(4'd0, 2'd3, 2'd0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    wait_drain();

    $display("[TB] held cmd_valid across busy");
    applyStimulus(4'd3, 2'd1, 2'd0, 1'b1, 8'h33, 3'd0, 1'b1, 1'b0);
    applyStimulus(4'd3, 2'd2, 2'd0, 1'b1, 8'hC4, 3'd0, 1'b1, 1'b0);
    wait_drain();
    d0 = done_seen;
    applyStimulus(4'd0, 2'd1, 2'd2, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1);
    applyStimulus(4'd1, 2'd2, 2'd1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    wait_drain();
    checkOutput("held_two_done", done_seen - d0, 2);

    $display("[TB] randomized commands");
    for (int k = 0; k < 60; k++) begin
      r_op      = 4'($urandom_range(0, 15));
      r_rd      = 2'($urandom_range(0, 3));
      r_rs      = 2'($urandom_range(0, 3));
      r_imm_sel = 1'($urandom_range(0, 1));
      r_imm     = 8'($urandom_range(0, 255));
      r_cnt     = 3'($urandom_range(0, 7));
      applyStimulus(r_op, r_rd, r_rs, r_imm_sel, r_imm, r_cnt, 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #1;
      end
    end
    wait_drain();
    check_idle_alu();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
